// File: rtl/spi_frame_receiver.sv
// Parses command/address/payload frames from an SPI slave byte stream and
// commits good payloads into a registered, little-endian sensor data vector.
module spi_frame_receiver #(
  parameter int         NUM_SENSORS = 8,
  parameter logic [7:0] CMD_WRITE   = 8'h02
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       cs_n,
  input  logic                       do_valid,
  input  logic [7:0]                 do_byte,
  output logic [32*NUM_SENSORS-1:0]  data,
  output logic                       frame_valid,
  output logic                       frame_error,
  output logic [7:0]                 last_length,
  output logic [7:0]                 error_count,
  output logic [2:0]                 dbg_state
);

  localparam int         P  = 4 * NUM_SENSORS;
  localparam int         DW = 8 * P;
  localparam logic [8:0] P9 = 9'(P);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  // Handshake: do_valid is a one-cycle strobe with no backpressure; every
  // cycle with do_valid=1 carries exactly one byte on do_byte, in any state.

  state_t          r_state;
  state_t          w_state_nxt;
  state_t          w_byte_state;
  logic [DW-1:0]   r_shadow;
  logic [DW-1:0]   w_shadow_nxt;
  logic [DW-1:0]   r_data;
  logic [7:0]      r_index;
  logic [7:0]      w_index_nxt;
  logic [7:0]      r_count;
  logic [7:0]      w_count_nxt;
  logic            w_store;
  logic            w_load;
  logic            w_commit;
  logic            w_reject;
  logic            r_frame_valid;
  logic            r_frame_error;
  logic [7:0]      r_last_length;
  logic [7:0]      r_error_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // The byte of this cycle is applied first; a cs_n=1 sample then closes the
  // frame using the post-byte state and count.
  always_comb begin
    w_state_nxt  = r_state;
    w_byte_state = r_state;
    w_index_nxt  = r_index;
    w_count_nxt  = r_count;
    w_store      = 1'b0;
    w_load       = 1'b0;
    w_commit     = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!cs_n) begin
          w_load      = 1'b1;
          w_index_nxt = 8'd0;
          w_count_nxt = 8'd0;
        end
      end
      S_CMD: begin
        if (do_valid) w_byte_state = (do_byte == CMD_WRITE) ? S_ADDR : S_DISCARD;
      end
      S_ADDR: begin
        if (do_valid) begin
          if ({1'b0, do_byte} < P9) begin
            w_index_nxt  = do_byte;
            w_byte_state = S_PAYLOAD;
          end else begin
            w_byte_state = S_DISCARD;
          end
        end
      end
      S_PAYLOAD: begin
        if (do_valid) begin
          if ({1'b0, r_index} < P9) begin
            w_store     = 1'b1;
            w_index_nxt = r_index + 8'd1;
            w_count_nxt = r_count + 8'd1;
          end else begin
            w_byte_state = S_DISCARD;
          end
        end
      end
      S_DISCARD: ;
      default: w_byte_state = S_IDLE;
    endcase

    if (r_state == S_IDLE) begin
      if (!cs_n) w_state_nxt = S_CMD;
    end else if (cs_n) begin
      w_state_nxt = S_IDLE;
      if (w_byte_state == S_PAYLOAD && w_count_nxt != 8'd0) w_commit = 1'b1;
      else                                                   w_reject = 1'b1;
    end else begin
      w_state_nxt = w_byte_state;
    end
  end

  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int k = 0; k < P; k++) begin
      if (w_store && r_index == 8'(k)) w_shadow_nxt[8*k +: 8] = do_byte;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow      <= '0;
      r_data        <= '0;
      r_index       <= 8'd0;
      r_count       <= 8'd0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_last_length <= 8'd0;
      r_error_count <= 8'd0;
    end else begin
      r_shadow      <= w_load ? r_data : w_shadow_nxt;
      r_index       <= w_index_nxt;
      r_count       <= w_count_nxt;
      r_frame_valid <= w_commit;
      r_frame_error <= w_reject;
      if (w_commit) begin
        r_data        <= w_shadow_nxt;
        r_last_length <= w_count_nxt;
      end
      if (w_reject && r_error_count != 8'hFF) r_error_count <= r_error_count + 8'd1;
    end
  end

  assign data        = r_data;
  assign frame_valid = r_frame_valid;
  assign frame_error = r_frame_error;
  assign last_length = r_last_length;
  assign error_count = r_error_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Randomized bench for spi_frame_receiver: frames are scored against a
// frame-level model that applies the accept/reject rules to whole byte lists.
module tb_spi_frame_receiver;

  localparam int NS = 8;
  localparam int P  = 4 * NS;
  localparam int DW = 8 * P;

  logic          clock;
  logic          reset_n;
  logic          cs_n;
  logic          do_valid;
  logic [7:0]    do_byte;
  logic [DW-1:0] data;
  logic          frame_valid;
  logic          frame_error;
  logic [7:0]    last_length;
  logic [7:0]    error_count;
  logic [2:0]    dbg_state;

  spi_frame_receiver #(.NUM_SENSORS(NS), .CMD_WRITE(8'h02)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cs_n       (cs_n),
    .do_valid   (do_valid),
    .do_byte    (do_byte),
    .data       (data),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .last_length(last_length),
    .error_count(error_count),
    .dbg_state  (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int            n_vec = 0;
  int            n_mis = 0;
  logic [DW-1:0] exp_data;
  logic [7:0]    exp_len;
  logic [7:0]    exp_err;
  logic [7:0]    frm_q[$];

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-frame rule: write command, in-range start address, and a payload of
  // 1..(P-addr) bytes commits; anything else is a rejected frame.
  task automatic model_frame(output bit ok);
    int a;
    int n;
    ok = 1'b0;
    a  = 0;
    n  = frm_q.size();
    if (n >= 3 && frm_q[0] == 8'h02) begin
      a = int'(frm_q[1]);
      if (a < P && a + n - 2 <= P) ok = 1'b1;
    end
    if (ok) begin
      for (int i = 2; i < n; i++) exp_data[8*(a+i-2) +: 8] = frm_q[i];
      exp_len = 8'(n - 2);
    end else if (exp_err != 8'hFF) begin
      exp_err = exp_err + 8'd1;
    end
  endtask

  task automatic send_frame(input bit coincident, input int max_gap, input int max_idle);
    bit ok;
    int n;
    n = frm_q.size();
    model_frame(ok);
    repeat ($urandom_range(0, max_idle)) @(negedge clock);
    @(negedge clock);
    check_eq("pulse_clear", {frame_valid, frame_error}, '0);
    cs_n     = 1'b0;
    do_valid = 1'($urandom_range(0, 1));
    do_byte  = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clock);
        do_valid = 1'b0;
      end
      @(negedge clock);
      do_valid = 1'b1;
      do_byte  = frm_q[i];
      if (coincident && i == n - 1) cs_n = 1'b1;
    end
    if (!(coincident && n > 0)) begin
      @(negedge clock);
      do_valid = 1'b0;
      cs_n     = 1'b1;
    end
    @(negedge clock);
    do_valid = 1'b0;
    cs_n     = 1'b1;
    check_eq("frame_valid", frame_valid, ok);
    check_eq("frame_error", frame_error, !ok);
    check_eq("data", data, exp_data);
    check_eq("last_length", last_length, exp_len);
    check_eq("error_count", error_count, exp_err);
  endtask

  task automatic random_frame();
    int addr;
    int len;
    frm_q.delete();
    if ($urandom_range(0, 15) != 0) begin
      frm_q.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h02);
      addr = ($urandom_range(0, 7) == 0) ? $urandom_range(P, 255) : $urandom_range(0, P - 1);
      if ($urandom_range(0, 15) != 0) begin
        frm_q.push_back(8'(addr));
        if ($urandom_range(0, 5) == 0) len = $urandom_range(0, P + 4);
        else if (addr < P)             len = $urandom_range(1, P - addr);
        else                           len = $urandom_range(0, 4);
        for (int i = 0; i < len; i++) frm_q.push_back(8'($urandom));
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    cs_n     = 1'b1;
    do_valid = 1'b0;
    do_byte  = 8'h00;
    exp_data = '0;
    exp_len  = 8'd0;
    exp_err  = 8'd0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("rst_data", data, '0);
    check_eq("rst_pulses", {frame_valid, frame_error}, '0);
    check_eq("rst_len", last_length, '0);
    check_eq("rst_err", error_count, '0);

    frm_q = {8'h02, 8'h00};
    for (int i = 0; i < P; i++) frm_q.push_back(8'(i));
    send_frame(1'b0, 0, 0);
    check_eq("full_w0", data[31:0], 32'h03020100);
    check_eq("full_w7", data[255:224], 32'h1F1E1D1C);
    check_eq("full_len", last_length, 8'd32);

    frm_q = {8'h02, 8'h08, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(1'b0, 1, 0);
    check_eq("part_w2", data[95:64], 32'hDDCCBBAA);
    check_eq("part_w3", data[127:96], 32'h0F0E0D0C);

    frm_q = {8'h03, 8'h00, 8'h11};
    send_frame(1'b0, 0, 0);
    check_eq("badcmd_err", error_count, 8'd1);
    frm_q = {8'h02, 8'h20};
    send_frame(1'b0, 0, 0);
    frm_q = {8'h02};
    send_frame(1'b0, 0, 0);
    frm_q = {8'h02, 8'h1E, 8'h01, 8'h02, 8'h03};
    send_frame(1'b0, 0, 0);
    check_eq("ovf_b30", data[247:240], 8'h1E);
    check_eq("ovf_err", error_count, 8'd4);

    frm_q = {8'h02, 8'h04, 8'hA1, 8'hB2};
    send_frame(1'b1, 0, 0);
    check_eq("coinc_w1", data[47:32], 16'hB2A1);

    for (int t = 0; t < 150; t++) begin
      random_frame();
      send_frame(1'($urandom_range(0, 1)), 2, 2);
    end

    for (int t = 0; t < 300; t++) begin
      frm_q = {8'h03};
      send_frame(1'b0, 0, 0);
    end
    check_eq("sat_err", error_count, 8'hFF);

    @(negedge clock);
    cs_n = 1'b0;
    frm_q = {8'h02, 8'h00, 8'h55};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      do_valid = 1'b1;
      do_byte  = frm_q[i];
    end
    @(negedge clock);
    do_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_eq("mid_rst_data", data, '0);
    check_eq("mid_rst_out", {frame_valid, frame_error, last_length, error_count}, '0);
    cs_n = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_pulse", {frame_valid, frame_error}, '0);
    reset_n  = 1'b1;
    exp_data = '0;
    exp_len  = 8'd0;
    exp_err  = 8'd0;
    frm_q = {8'h02, 8'h00};
    for (int i = 0; i < P; i++) frm_q.push_back(8'($urandom));
    send_frame(1'b0, 1, 1);
    @(negedge clock);
    check_eq("final_pulse", {frame_valid, frame_error}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Receiving end of the sensor-data SPI link. Consumes the byte stream from an SPI slave core and parses frames of the form command byte, start-address byte, payload bytes. Valid payload is reassembled into a 32-bit-per-sensor data vector. It sits behind the SPI slave on the far side of the link, or in a loopback bench, and turns the byte stream back into the `data` bus the transmitter side serialises.

## Interface
Parameters:
- NUM_SENSORS, 8, number of 32-bit sensor words; payload length P = 4*NUM_SENSORS bytes (32 by default, at most 255).
- CMD_WRITE, 8'h02, only accepted command byte.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cs_n  in  1  SPI chip select from the slave core, active low, already synchronous to clock; frame delimiter.
- do_valid  in  1  one-cycle strobe: a received byte is on do_byte.
- do_byte  in  8  received byte.
- data  out  8*P  reassembled payload; byte k at data[8k+7:8k]; sensor n word = data[32n+31:32n], little-endian (first byte = LSB).
- frame_valid  out  1  one-cycle pulse: data was updated by a good frame.
- frame_error  out  1  one-cycle pulse: frame rejected.
- last_length  out  8  payload byte count of the last committed frame.
- error_count  out  8  rejected frames, saturating at 255.

## Operation
- Reset: data=0, frame_valid=0, frame_error=0, last_length=0, error_count=0, state IDLE, index=0.
- Internal shadow buffer (8*P bits) and byte index (8 bits).
- States:
  - IDLE: wait for cs_n=0. On cs_n=0, copy shadow <= data, go to CMD. do_valid is ignored while cs_n=1.
  - CMD: on do_valid, go to ADDR if do_byte==CMD_WRITE, else go to DISCARD.
  - ADDR: on do_valid, if do_byte < P then index <= do_byte and go to PAYLOAD; else go to DISCARD.
  - PAYLOAD: on do_valid, if index < P then shadow byte[index] <= do_byte and index++; else (overflow) go to DISCARD.
  - DISCARD: consume bytes without storing until frame end.
- Frame end is a cycle with cs_n=1 while in any state except IDLE:
  - PAYLOAD with ≥1 payload byte stored: data <= shadow, last_length <= bytes stored, pulse frame_valid, go to IDLE.
  - PAYLOAD with 0 bytes, or CMD, ADDR, DISCARD: pulse frame_error, error_count++ (saturating), go to IDLE. data and last_length are unchanged.
- Partial frames with a nonzero start address update only the addressed bytes; all other bytes keep their previous values because the shadow is preloaded.
- Index arithmetic is 8-bit unsigned. index == P means the buffer is full; the next byte is an overflow, not a wrap-around.

## Timing
- frame_valid, frame_error, data and last_length are all registered. They update in the cycle after the first cs_n=1 sample; frame_valid is high for exactly 1 cycle.
- do_valid in the same cycle as the cs_n rising sample: the byte is processed first (stored or rejected), then the frame closes using the updated count and state.
- cs_n falling and do_valid in the same cycle: the shadow is loaded, the byte is ignored, and the state becomes CMD.
- Back-to-back frames: cs_n may go low again 1 cycle after the closing cycle. There is no dead time requirement beyond the IDLE cycle.
- Reset asserted mid-frame: everything returns to reset values immediately; no pulse is produced.
- Throughput: one byte per cycle is accepted in every state.

## Test plan
- Full frame: cs_n low, bytes 02, 00, 00..1F, cs_n high -> data[31:0]=32'h03020100, data[255:224]=32'h1F1E1D1C, frame_valid for 1 cycle, last_length=32, frame_error=0.
- Partial update after the full frame: 02, 08, AA, BB, CC, DD -> data[95:64]=32'hDDCCBBAA, all other words unchanged, last_length=4, frame_valid pulse.
- Rejections:
  - Bad command 03, 00, 11 -> frame_error pulse, error_count=1, data unchanged.
  - Bad address 02, 20 -> frame_error pulse, data unchanged.
  - Short frame (02 only) -> frame_error pulse, data unchanged.
- Overflow: 02, 1E, 01, 02, 03 -> frame_error pulse, bytes 30/31 not committed, error_count increments.
- Boundary timing:
  - Last byte's do_valid coincident with the cs_n rising sample -> byte included, frame_valid the next cycle.
  - 300 bad frames -> error_count saturates at 255.
- Reset mid-frame: after 02, 00, 55, assert reset_n=0 -> all outputs 0, no pulse. A full frame after release is received correctly.
